seq_mul_bcd: RTL and testbench



---
 rtl/seq_mul_bcd_if.sv | 21 ++
 rtl/seq_mul_bcd.sv | 175 +++++++++++++++++
 tb/tb_seq_mul_bcd.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_mul_bcd_if.sv
// Request/result bus of seq_mul_bcd. The requester drives start/a/b; the
// multiplier returns busy/done plus the held product and its packed BCD digits.
interface seq_mul_bcd_if #(
    parameter int N          = 8,
    parameter int BCD_DIGITS = 5
);
    logic                    start;
    logic [N-1:0]            a;
    logic [N-1:0]            b;
    logic                    busy;
    logic                    done;
    logic [2*N-1:0]          result;
    logic [4*BCD_DIGITS-1:0] bcd;
    logic                    bcd_ovf;

    // start is a request level: it is taken only when the multiplier is idle and
    // not busy, and is otherwise ignored (no queueing). busy covers accept..done
    // inclusive; done pulses for one cycle when result/bcd/bcd_ovf update.
    modport master (output start, a, b, input busy, done, result, bcd, bcd_ovf);
    modport slave  (input start, a, b, output busy, done, result, bcd, bcd_ovf);
endinterface

// File: rtl/seq_mul_bcd.sv
// Sequential shift-add N x N multiplier followed by a double-dabble BCD converter.
// Macro SEQ_MUL_BCD_EN enables the BCD stage; undefined, bcd/bcd_ovf are tied to 0.
module seq_mul_bcd #(
    parameter int N          = 8,
    parameter int BCD_DIGITS = 5
) (
    input  logic          clk,
    input  logic          reset,
    seq_mul_bcd_if.slave  bus,
    output logic [1:0]    dbg_state_o
);
    localparam int PW = 2 * N;
    localparam int DW = 4 * BCD_DIGITS;
    localparam int CW = $clog2(PW + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
`ifdef SEQ_MUL_BCD_EN
        S_BCD  = 2'd2,
`endif
        S_DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   mcand_q, mcand_d;
    logic [N-1:0]    mplier_q, mplier_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [PW-1:0]   result_q, result_d;

`ifdef SEQ_MUL_BCD_EN
    logic [DW-1:0]   dig_q, dig_d;
    logic            dovf_q, dovf_d;
    logic [DW-1:0]   bcd_q, bcd_d;
    logic            bcd_ovf_q, bcd_ovf_d;
    logic [DW-1:0]   dig_adj;

    // Digits are <= 9 before each shift, so the +3 never carries across digits.
    function automatic logic [DW-1:0] add3(input logic [DW-1:0] x);
        logic [DW-1:0] y;
        y = x;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (x[4*i +: 4] >= 4'd5) y[4*i +: 4] = x[4*i +: 4] + 4'd3;
        end
        return y;
    endfunction

    assign dig_adj = add3(dig_q);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
`ifdef SEQ_MUL_BCD_EN
            dig_q     <= '0;
            dovf_q    <= 1'b0;
            bcd_q     <= '0;
            bcd_ovf_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
`ifdef SEQ_MUL_BCD_EN
            dig_q     <= dig_d;
            dovf_q    <= dovf_d;
            bcd_q     <= bcd_d;
            bcd_ovf_q <= bcd_ovf_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        // busy falls on the edge after the done pulse; done itself lasts one cycle.
        busy_d    = busy_q & ~done_q;
        done_d    = 1'b0;
        result_d  = result_q;
`ifdef SEQ_MUL_BCD_EN
        dig_d     = dig_q;
        dovf_d    = dovf_q;
        bcd_d     = bcd_q;
        bcd_ovf_d = bcd_ovf_q;
`endif

        case (state_q)
            S_IDLE: begin
                // The done cycle is still a busy cycle, so a start there is not taken.
                if (bus.start && !done_q) begin
                    mcand_d  = {{N{1'b0}}, bus.a};
                    mplier_d = bus.b;
                    acc_d    = '0;
                    cnt_d    = CW'(N);
                    busy_d   = 1'b1;
`ifdef SEQ_MUL_BCD_EN
                    dig_d    = '0;
                    dovf_d   = 1'b0;
`endif
                    state_d  = S_MUL;
                end
            end

            S_MUL: begin
                if (mplier_q[0]) acc_d = acc_q + mcand_q;
                mcand_d  = {mcand_q[PW-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[N-1:1]};
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
`ifdef SEQ_MUL_BCD_EN
                    cnt_d   = CW'(PW);
                    state_d = S_BCD;
`else
                    state_d = S_DONE;
`endif
                end
            end

`ifdef SEQ_MUL_BCD_EN
            S_BCD: begin
                // acc is rotated rather than shifted: after 2N steps it holds the
                // product again, so no separate copy of the product is needed.
                dig_d  = {dig_adj[DW-2:0], acc_q[PW-1]};
                acc_d  = {acc_q[PW-2:0], acc_q[PW-1]};
                dovf_d = dovf_q | dig_adj[DW-1];
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = S_DONE;
            end
`endif

            S_DONE: begin
                result_d  = acc_q;
`ifdef SEQ_MUL_BCD_EN
                bcd_d     = dig_q;
                bcd_ovf_d = dovf_q;
`endif
                done_d    = 1'b1;
                state_d   = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.result  = result_q;
`ifdef SEQ_MUL_BCD_EN
    assign bus.bcd     = bcd_q;
    assign bus.bcd_ovf = bcd_ovf_q;
`else
    assign bus.bcd     = '0;
    assign bus.bcd_ovf = 1'b0;
`endif
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seq_mul_bcd.sv
// Self-checking bench for seq_mul_bcd: scoreboard of expected products/BCD
// values checked on each done pulse, plus per-scenario inline checks.
module tb_seq_mul_bcd;
  localparam int N  = 8;
  localparam int D  = 5;
  localparam int PW = 2 * N;
  localparam int DW = 4 * D;
  localparam int W  = 1 + DW + PW;
`ifdef SEQ_MUL_BCD_EN
  localparam int LAT    = 3 * N + 1;
  localparam bit BCD_ON = 1'b1;
`else
  localparam int LAT    = N + 1;
  localparam bit BCD_ON = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  seq_mul_bcd_if #(.N(N), .BCD_DIGITS(D)) bus ();
  seq_mul_bcd_if #(.N(N), .BCD_DIGITS(4)) bus4 ();
  logic [1:0] dbg_state;
  logic [1:0] dbg_state4;

  seq_mul_bcd #(.N(N), .BCD_DIGITS(D)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave), .dbg_state_o(dbg_state)
  );
  seq_mul_bcd #(.N(N), .BCD_DIGITS(4)) dut4 (
    .clk(clk), .reset(reset), .bus(bus4.slave), .dbg_state_o(dbg_state4)
  );

  int checks = 0;
  int passed = 0;

  logic [W-1:0] exp_q[$];
  int           t0_q[$];

  // reference: decimal digits by repeated division
  function automatic logic [W-1:0] expect_val(input int ea, input int eb, input int digits);
    int prod, v, lim;
    logic [DW-1:0] bd;
    logic ov;
    prod = ea * eb;
    v = prod;
    lim = 1;
    bd = '0;
    for (int i = 0; i < digits; i++) begin
      bd[4*i +: 4] = 4'(v % 10);
      v = v / 10;
      lim = lim * 10;
    end
    ov = (prod >= lim);
    if (!BCD_ON) begin
      bd = '0;
      ov = 1'b0;
    end
    return {ov, bd, 16'(prod)};
  endfunction

  // scoreboard: compare on every done pulse
  always @(negedge clk) begin
    logic [W-1:0] e;
    int t0;
    if (bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done at cycle %0d result=%0d", cyc, bus.result);
      end else begin
        e  = exp_q.pop_front();
        t0 = t0_q.pop_front();
        checks++;
        if (bus.result === e[PW-1:0]) passed++;
        else $display("FAIL result got=%0d exp=%0d", bus.result, e[PW-1:0]);
        checks++;
        if (bus.bcd === e[PW +: DW]) passed++;
        else $display("FAIL bcd got=%h exp=%h", bus.bcd, e[PW +: DW]);
        checks++;
        if (bus.bcd_ovf === e[W-1]) passed++;
        else $display("FAIL bcd_ovf got=%b exp=%b", bus.bcd_ovf, e[W-1]);
        checks++;
        if (cyc - t0 == LAT) passed++;
        else $display("FAIL latency got=%0d exp=%0d", cyc - t0, LAT);
      end
    end
  end

  // driver: wait for idle, present one start pulse, scramble operands after accept
  task automatic issue(input int ta, input int tb);
    int guard = 0;
    @(negedge clk);
    while ((bus.busy !== 1'b0 || bus.done !== 1'b0) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      checks++;
      $display("FAIL issue_timeout busy=%b required=0", bus.busy);
    end
    bus.start = 1'b1;
    bus.a = 8'(ta);
    bus.b = 8'(tb);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a = 8'($urandom_range(0, 255));
    bus.b = 8'($urandom_range(0, 255));
    exp_q.push_back(expect_val(ta, tb, D));
    t0_q.push_back(cyc);
    checks++;
    if (bus.busy === 1'b1) passed++;
    else $display("FAIL accept_busy got=%b exp=1", bus.busy);
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain_timeout pending=%0d exp=0", exp_q.size());
      exp_q.delete();
      t0_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.bcd_ovf} === 3'b000) passed++;
    else $display("FAIL reset_flags got=%b exp=000", {bus.busy, bus.done, bus.bcd_ovf});
    checks++;
    if (bus.result === '0) passed++;
    else $display("FAIL reset_result got=%0d exp=0", bus.result);
    checks++;
    if (bus.bcd === '0) passed++;
    else $display("FAIL reset_bcd got=%h exp=0", bus.bcd);
    checks++;
    if (dbg_state === 2'd0) passed++;
    else $display("FAIL reset_state got=%0d exp=0", dbg_state);
    reset = 1'b1;
  endtask

  task automatic test_basic();
    int ta[4] = '{10, 255, 0, 99};
    int tb[4] = '{20, 255, 123, 1};
    for (int i = 0; i < 4; i++) begin
      issue(ta[i], tb[i]);
      drain();
    end
  endtask

  task automatic test_ignore_start();
    issue(45, 22);
    repeat (4) @(negedge clk);
    bus.a = 8'd4;
    bus.b = 8'd16;
    bus.start = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.busy === 1'b1) passed++;
    else $display("FAIL busy_mid_op got=%b exp=1", bus.busy);
    bus.start = 1'b0;
    drain();
    issue(4, 16);
    drain();
  endtask

  task automatic test_hold_start();
    int t0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 8'd3;
    bus.b = 8'd5;
    @(posedge clk);
    #1;
    t0 = cyc;
    exp_q.push_back(expect_val(3, 5, D));
    t0_q.push_back(t0);
    bus.a = 8'd9;
    bus.b = 8'd11;
    exp_q.push_back(expect_val(9, 11, D));
    t0_q.push_back(t0 + LAT + 2);
    repeat (LAT + 2) @(posedge clk);
    #1;
    checks++;
    if (bus.busy === 1'b1) passed++;
    else $display("FAIL held_start_reaccept busy=%b exp=1", bus.busy);
    bus.start = 1'b0;
    drain();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) issue($urandom_range(0, 255), $urandom_range(0, 255));
    drain();
  endtask

  task automatic test_reset_mid();
    issue(200, 150);
    repeat (9) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    exp_q.delete();
    t0_q.delete();
    checks++;
    if ({bus.busy, bus.done, bus.bcd_ovf} === 3'b000) passed++;
    else $display("FAIL midreset_flags got=%b exp=000", {bus.busy, bus.done, bus.bcd_ovf});
    checks++;
    if (bus.result === '0 && bus.bcd === '0) passed++;
    else $display("FAIL midreset_data result=%0d bcd=%h exp=0", bus.result, bus.bcd);
    checks++;
    if (dbg_state === 2'd0) passed++;
    else $display("FAIL midreset_state got=%0d exp=0", dbg_state);
    @(negedge clk);
    reset = 1'b1;
    issue(13, 7);
    drain();
  endtask

  task automatic test_bcd_ovf();
    logic [W-1:0] e;
    int guard = 0;
    e = expect_val(255, 255, 4);
    @(negedge clk);
    bus4.start = 1'b1;
    bus4.a = 8'd255;
    bus4.b = 8'd255;
    @(posedge clk);
    #1;
    bus4.start = 1'b0;
    while (bus4.done !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (bus4.done === 1'b1 && bus4.bcd_ovf === e[W-1]) passed++;
    else $display("FAIL ovf4 done=%b got=%b exp=%b", bus4.done, bus4.bcd_ovf, e[W-1]);
    checks++;
    if (bus4.bcd === e[PW +: 16]) passed++;
    else $display("FAIL bcd4 got=%h exp=%h", bus4.bcd, e[PW +: 16]);
    checks++;
    if (bus4.result === 16'hFE01) passed++;
    else $display("FAIL result4 got=%h exp=fe01", bus4.result);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus4.start = 1'b0;
    bus4.a = '0;
    bus4.b = '0;
    reset = 1'b1;
    #1 reset = 1'b0;
    test_reset();
    test_basic();
    test_ignore_start();
    test_hold_start();
    test_back_to_back();
    test_reset_mid();
    test_bcd_ovf();
    drain();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
